// File: rtl/ram_stream_reader.sv
// Sequential RAM read client: issues addresses to a 2-cycle-latency RAM and
// streams the returned words over valid/ready, with credit-based backpressure.
module ram_stream_reader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned BUF_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rdaddr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CRD_W = PTR_W + 1;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]      issue_cnt_q;
  logic [CNT_W-1:0]      pop_cnt_q;
  logic [CRD_W-1:0]      credit_q;
  logic [CRD_W-1:0]      credit_d;
  logic                  v1_q;
  logic                  v2_q;
  logic [CRD_W-1:0]      wr_ptr_q;
  logic [CRD_W-1:0]      rd_ptr_q;
  logic                  busy_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
  logic                  issue_c;
  logic                  pop_c;

  // Credit covers both in-flight reads and buffered words, so the buffer never overflows.
  assign issue_c   = (state_q == S_ISSUE) && (credit_q < CRD_W'(BUF_DEPTH));
  assign out_valid = (wr_ptr_q != rd_ptr_q);
  assign pop_c     = out_valid && out_ready;
  assign out_data  = buf_q[rd_ptr_q[PTR_W-1:0]];
  assign rdaddr    = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

  always_comb begin
    credit_d = credit_q;
    if (issue_c && !pop_c) begin
      credit_d = credit_q + CRD_W'(1);
    end else if (pop_c && !issue_c) begin
      credit_d = credit_q - CRD_W'(1);
    end
  end

  // Buffer storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (v2_q) begin
      buf_q[wr_ptr_q[PTR_W-1:0]] <= ram_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      pop_cnt_q   <= '0;
      credit_q    <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      v1_q     <= issue_c;
      v2_q     <= v1_q;
      credit_q <= credit_d;
      done_q   <= 1'b0;
      if (v2_q) begin
        wr_ptr_q <= wr_ptr_q + CRD_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + CRD_W'(1);
      end
      if (pop_c && (pop_cnt_q != '0)) begin
        pop_cnt_q <= pop_cnt_q - CNT_W'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q      <= 1'b1;
            addr_q      <= base_addr;
            issue_cnt_q <= length;
            pop_cnt_q   <= length;
            state_q     <= (length != '0) ? S_ISSUE : S_DRAIN;
          end
        end
        S_ISSUE: begin
          if (issue_c) begin
            addr_q      <= addr_q + ADDR_WIDTH'(1);
            issue_cnt_q <= issue_cnt_q - CNT_W'(1);
            if (issue_cnt_q == CNT_W'(1)) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Finish on the final pop so done appears the very next cycle.
          if ((pop_cnt_q == '0) || (pop_c && (pop_cnt_q == CNT_W'(1)))) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a 2-cycle-latency RAM model.
module tb_ram_stream_reader;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 5;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic [AW-1:0] rdaddr;
  logic [DW-1:0] ram_q;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BUF_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .rdaddr(rdaddr),
    .ram_q(ram_q), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: address sampled at edge k, data on ram_q after edge k+1.
  logic [DW-1:0] mem [32];
  logic [DW-1:0] rd1, rd2;
  initial for (int i = 0; i < 32; i++) mem[i] = 16'h100 + DW'(i);
  always @(posedge clk) begin
    rd1 <= mem[rdaddr];
    rd2 <= rd1;
  end
  assign ram_q = rd2;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor state, sampled on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] rx_q [$];
  int issued, popped, max_credit, done_cnt, done_cyc, last_pop_cyc;
  int first_valid_cyc, start_cyc;
  bit pend_pop, prev_busy, any_valid;
  logic [AW-1:0] prev_rd;

  always @(negedge clk) begin
    if (prev_busy && busy && (rdaddr != prev_rd)) issued++;
    if (pend_pop) popped++;
    if (issued - popped > max_credit) max_credit = issued - popped;
    pend_pop = out_valid && out_ready && !reset;
    if (pend_pop) begin
      rx_q.push_back(out_data);
      last_pop_cyc = cyc;
    end
    if (out_valid) any_valid = 1'b1;
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (done && !reset) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (start && !busy && !reset && start_cyc < 0) start_cyc = cyc;
    prev_busy = busy;
    prev_rd   = rdaddr;
  end

  task automatic clear_track();
    rx_q.delete();
    issued = 0; popped = 0; max_credit = 0; done_cnt = 0; done_cyc = -1;
    last_pop_cyc = -1; first_valid_cyc = -1; start_cyc = -1; any_valid = 1'b0;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_until_done(input string tag, input int budget, input bit rand_rdy);
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
    chk({tag, "_timeout"}, 32'(done_cnt != 0), 32'd1);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic chk_words(input string tag, input logic [AW-1:0] b, input int n);
    chk({tag, "_count"}, 32'(rx_q.size()), 32'(n));
    for (int i = 0; i < n && i < rx_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), 32'(rx_q[i]), 32'(16'h100 + 16'((b + i) % 32)));
  endtask

  bit frozen_bad;
  bit seen_valid_stall;

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
    clear_track();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_rdaddr", 32'(rdaddr), 32'd0);
    reset = 1'b0;

    // Basic transfer: base 3, length 5.
    clear_track();
    do_start(5'd3, 6'd5);
    run_until_done("t1", 40, 1'b0);
    chk("t1_first_valid", 32'(first_valid_cyc - start_cyc), 32'd4);
    chk_words("t1", 5'd3, 5);
    chk("t1_consecutive", 32'(last_pop_cyc - first_valid_cyc), 32'd4);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_done_delay", 32'(done_cyc - last_pop_cyc), 32'd1);
    chk("t1_busy_after", 32'(busy), 32'd0);

    // Address wrap: 30, 31, 0, 1.
    clear_track();
    do_start(5'd30, 6'd4);
    run_until_done("t2", 40, 1'b0);
    chk_words("t2", 5'd30, 4);
    chk("t2_done_cnt", 32'(done_cnt), 32'd1);

    // Backpressure: ready low for 10 cycles after start.
    clear_track();
    out_ready = 1'b0;
    do_start(5'd5, 6'd8);
    frozen_bad = 1'b0;
    seen_valid_stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen_valid_stall = 1'b1;
        if (out_data !== 16'h105) frozen_bad = 1'b1;
      end
    end
    chk("t3_issued_stall", 32'(issued), 32'd4);
    chk("t3_valid_stall", 32'(seen_valid_stall), 32'd1);
    chk("t3_frozen", 32'(frozen_bad), 32'd0);
    chk("t3_head", 32'(out_data), 32'h105);
    @(posedge clk); #1;
    out_ready = 1'b1;
    run_until_done("t3", 60, 1'b0);
    chk_words("t3", 5'd5, 8);
    chk("t3_max_credit", 32'(max_credit <= 4), 32'd1);
    chk("t3_done_cnt", 32'(done_cnt), 32'd1);

    // Zero length: done only, no reads or output.
    clear_track();
    do_start(5'd12, 6'd0);
    run_until_done("t4", 10, 1'b0);
    chk("t4_done_cnt", 32'(done_cnt), 32'd1);
    chk("t4_done_delay", 32'(done_cyc - start_cyc), 32'd2);
    chk("t4_no_valid", 32'(any_valid), 32'd0);
    chk("t4_no_issue", 32'(issued), 32'd0);

    // Random backpressure over the full RAM.
    clear_track();
    do_start(5'd9, 6'd32);
    run_until_done("t5", 600, 1'b1);
    chk_words("t5", 5'd9, 32);
    chk("t5_issued", 32'(issued), 32'd32);
    chk("t5_max_credit", 32'(max_credit <= 4), 32'd1);
    chk("t5_done_cnt", 32'(done_cnt), 32'd1);

    // Reset mid-transfer, then a fresh short transfer.
    clear_track();
    do_start(5'd7, 6'd10);
    for (int i = 0; i < 40 && rx_q.size() < 3; i++) begin
      @(posedge clk); #1;
    end
    chk("t6_pre_words", 32'(rx_q.size()), 32'd3);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_rdaddr", 32'(rdaddr), 32'd0);
    chk("t6_rst_no_done", 32'(done_cnt), 32'd0);
    reset = 1'b0;
    clear_track();
    do_start(5'd0, 6'd2);
    run_until_done("t6", 30, 1'b0);
    chk_words("t6", 5'd0, 2);
    chk("t6_done_cnt", 32'(done_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
